regfile_access_arbiter: RTL and testbench

//   Shares the single Register File port between two requesters: m0 (system controller
//   Rx path) and m1 (config/debug loader). Round-robin arbitration, one access at a time.

---
 rtl/regfile_access_arbiter_if.sv | 52 +++++
 rtl/regfile_access_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_access_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_arbiter_if.sv
// Bundle of requester, Reg File and status signals around the Reg File access arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface regfile_access_arbiter_if #(
  parameter int width = 8,
  parameter int depth = 16
);
  localparam int AW = $clog2(depth);

  logic             m0_req;
  logic             m0_wr;
  logic [AW-1:0]    m0_addr;
  logic [width-1:0] m0_wdata;
  logic             m0_gnt;
  logic [width-1:0] m0_rdata;
  logic             m0_rvalid;
  logic             m0_rerr;

  logic             m1_req;
  logic             m1_wr;
  logic [AW-1:0]    m1_addr;
  logic [width-1:0] m1_wdata;
  logic             m1_gnt;
  logic [width-1:0] m1_rdata;
  logic             m1_rvalid;
  logic             m1_rerr;

  logic [width-1:0] RdData;
  logic             Rd_valid;
  logic [AW-1:0]    Reg_File_Adress;
  logic             WrEN;
  logic             RdEN;
  logic [width-1:0] WrData;
  logic             arb_busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  RdData, Rd_valid,
    output m0_gnt, m0_rdata, m0_rvalid, m0_rerr,
    output m1_gnt, m1_rdata, m1_rvalid, m1_rerr,
    output Reg_File_Adress, WrEN, RdEN, WrData, arb_busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output RdData, Rd_valid,
    input  m0_gnt, m0_rdata, m0_rvalid, m0_rerr,
    input  m1_gnt, m1_rdata, m1_rvalid, m1_rerr,
    input  Reg_File_Adress, WrEN, RdEN, WrData, arb_busy
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin sharing of the single Reg File port between two requesters,
// with a bounded wait for read data and per-requester read response routing.
module regfile_access_arbiter #(
  parameter int width      = 8,
  parameter int depth      = 16,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  regfile_access_arbiter_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  logic [0:0]       state;
  logic             rr_ptr;
  logic             owner;
  logic [CW-1:0]    tmo_cnt;

  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [1:0]       rerr;
  logic [width-1:0] rdata [2];
  logic [AW-1:0]    rf_addr;
  logic [width-1:0] rf_wdata;
  logic             wr_en;
  logic             rd_en;

  logic [1:0]       req;
  logic [1:0]       elig;
  logic             win;
  logic             grant_any;
  logic             sel_wr;
  logic [AW-1:0]    sel_addr;
  logic [width-1:0] sel_wdata;

  assign req = {bus.m1_req, bus.m0_req};

  // A requester granted last cycle is masked while it withdraws its request.
  always_comb begin
    elig      = req & ~gnt;
    grant_any = (state == IDLE) && (elig != '0);
    win       = 1'b0;
    case (elig)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~rr_ptr;
      default: win = 1'b0;
    endcase
    sel_wr    = win ? bus.m1_wr    : bus.m0_wr;
    sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b1;
      owner    <= 1'b0;
      tmo_cnt  <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      rerr     <= '0;
      rdata[0] <= '0;
      rdata[1] <= '0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      rerr   <= '0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            gnt[win] <= 1'b1;
            rr_ptr   <= win;
            rf_addr  <= sel_addr;
            if (sel_wr) begin
              wr_en    <= 1'b1;
              rf_wdata <= sel_wdata;
            end else begin
              rd_en   <= 1'b1;
              state   <= RD_WAIT;
              tmo_cnt <= '0;
              owner   <= win;
            end
          end
        end
        RD_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // Data arriving on the timeout edge still counts as a successful read.
          if (bus.Rd_valid) begin
            rdata[owner]  <= bus.RdData;
            rvalid[owner] <= 1'b1;
            state         <= IDLE;
          end else if (tmo_cnt == CW'(RD_TIMEOUT - 1)) begin
            rdata[owner]  <= '0;
            rvalid[owner] <= 1'b1;
            rerr[owner]   <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_gnt          = gnt[0];
  assign bus.m1_gnt          = gnt[1];
  assign bus.m0_rvalid       = rvalid[0];
  assign bus.m1_rvalid       = rvalid[1];
  assign bus.m0_rerr         = rerr[0];
  assign bus.m1_rerr         = rerr[1];
  assign bus.m0_rdata        = rdata[0];
  assign bus.m1_rdata        = rdata[1];
  assign bus.Reg_File_Adress = rf_addr;
  assign bus.WrData          = rf_wdata;
  assign bus.WrEN            = wr_en;
  assign bus.RdEN            = rd_en;
  assign bus.arb_busy        = (state == RD_WAIT);
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_regfile_access_arbiter;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = $clog2(D);
  localparam int TO = 4;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;

  regfile_access_arbiter_if #(.width(W), .depth(D)) bus ();

  regfile_access_arbiter #(.width(W), .depth(D), .RD_TIMEOUT(TO)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [1:0]    req = '0;
  logic [1:0]    wr  = '0;
  logic [AW-1:0] addr  [2];
  logic [W-1:0]  wdata [2];
  logic          rd_valid = 1'b0;
  logic [W-1:0]  rd_data  = '0;

  assign bus.m0_req   = req[0];
  assign bus.m0_wr    = wr[0];
  assign bus.m0_addr  = addr[0];
  assign bus.m0_wdata = wdata[0];
  assign bus.m1_req   = req[1];
  assign bus.m1_wr    = wr[1];
  assign bus.m1_addr  = addr[1];
  assign bus.m1_wdata = wdata[1];
  assign bus.Rd_valid = rd_valid;
  assign bus.RdData   = rd_data;

  // Reference model: Reg File contents and expected outputs for the upcoming cycle.
  logic [W-1:0]  mem [D];
  logic [1:0]    e_gnt, e_rvalid, e_rerr;
  logic          e_wr, e_rd, e_busy;
  logic [W-1:0]  e_rdata [2];
  logic [AW-1:0] e_addr;
  logic [W-1:0]  e_wdata;
  int            last;
  bit            rd_active;
  int            rd_owner, rd_done, valid_cyc;
  bit            rd_err;
  logic [W-1:0]  rd_val;
  logic [AW-1:0] rd_addr;
  int            force_k;
  bit            rand_mode, hold_req, stray_now;
  int            glog [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    check("m0_gnt",    32'(bus.m0_gnt),          32'(e_gnt[0]));
    check("m1_gnt",    32'(bus.m1_gnt),          32'(e_gnt[1]));
    check("WrEN",      32'(bus.WrEN),            32'(e_wr));
    check("RdEN",      32'(bus.RdEN),            32'(e_rd));
    check("addr",      32'(bus.Reg_File_Adress), 32'(e_addr));
    check("WrData",    32'(bus.WrData),          32'(e_wdata));
    check("m0_rvalid", 32'(bus.m0_rvalid),       32'(e_rvalid[0]));
    check("m1_rvalid", 32'(bus.m1_rvalid),       32'(e_rvalid[1]));
    check("m0_rerr",   32'(bus.m0_rerr),         32'(e_rerr[0]));
    check("m1_rerr",   32'(bus.m1_rerr),         32'(e_rerr[1]));
    check("m0_rdata",  32'(bus.m0_rdata),        32'(e_rdata[0]));
    check("m1_rdata",  32'(bus.m1_rdata),        32'(e_rdata[1]));
    check("arb_busy",  32'(bus.arb_busy),        32'(e_busy));
  endtask

  task automatic model_clear();
    e_gnt = '0; e_rvalid = '0; e_rerr = '0;
    e_wr = 1'b0; e_rd = 1'b0; e_busy = 1'b0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    e_addr = '0; e_wdata = '0;
    last = 1; rd_active = 1'b0; valid_cyc = -1;
  endtask

  task automatic new_op(input int x, input bit w);
    req[x]   = 1'b1;
    wr[x]    = w;
    addr[x]  = AW'($urandom_range(0, D - 1));
    wdata[x] = W'($urandom);
  endtask

  // Predict outputs of the next cycle from the requests presented on this edge.
  task automatic predict();
    logic [1:0] elig;
    int win, k, pick, n;
    n = cyc + 1;
    elig = req & ~e_gnt;
    e_gnt = '0; e_wr = 1'b0; e_rd = 1'b0; e_rvalid = '0; e_rerr = '0;
    if (rd_active) begin
      if (rd_done == n) begin
        rd_active = 1'b0;
        e_rvalid[rd_owner] = 1'b1;
        e_rerr[rd_owner]   = rd_err;
        e_rdata[rd_owner]  = rd_val;
      end
    end else if (elig != 2'b00) begin
      if (elig == 2'b11) win = 1 - last;
      else               win = elig[1] ? 1 : 0;
      last = win;
      e_gnt[win] = 1'b1;
      e_addr = addr[win];
      if (wr[win]) begin
        e_wr = 1'b1;
        e_wdata = wdata[win];
        mem[addr[win]] = wdata[win];
      end else begin
        e_rd = 1'b1;
        rd_active = 1'b1;
        rd_owner = win;
        rd_addr = addr[win];
        k = force_k;
        if (k == 0) begin
          pick = int'($urandom_range(0, 6));
          k = (pick < 3) ? 1 : (pick == 6) ? -1 : pick - 1;
        end
        valid_cyc = (k > 0) ? n + k : -1;
        if (k > 0 && k < TO) begin
          rd_done = n + k + 1; rd_err = 1'b0; rd_val = mem[addr[win]];
        end else begin
          rd_done = n + TO;    rd_err = 1'b1; rd_val = '0;
        end
      end
    end
    e_busy = rd_active;
  endtask

  task automatic step();
    rd_valid = (cyc == valid_cyc);
    rd_data  = rd_valid ? mem[rd_addr] : W'($urandom);
    if (!rd_valid && !rd_active && (stray_now || (rand_mode && $urandom_range(0, 7) == 0)))
      rd_valid = 1'b1;
    stray_now = 1'b0;
    predict();
    @(negedge CLK);
    check_all();
    if (bus.m0_gnt) glog.push_back(0);
    if (bus.m1_gnt) glog.push_back(1);
    for (int x = 0; x < 2; x++) begin
      if (e_gnt[x]) begin
        req[x] = 1'b0;
        if (hold_req) new_op(x, 1'b1);
        else if (rand_mode && $urandom_range(0, 1) == 1) new_op(x, 1'($urandom_range(0, 1)));
      end else if (rand_mode && !req[x] && $urandom_range(0, 3) == 0) begin
        new_op(x, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  // what: 0/1 = mX_gnt, 2/3 = mX_rvalid, 4 = RdEN
  task automatic run_until(input string tag, input int what, input int budget);
    logic [4:0] ev;
    for (int i = 0; i < budget; i++) begin
      step();
      ev = {bus.RdEN, bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt};
      if (ev[what]) return;
    end
    check({"wait_", tag}, 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    req = '0;
    rd_valid = 1'b0;
    model_clear();
    #1;
    check_all();
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = W'($urandom);
    for (int x = 0; x < 2; x++) begin addr[x] = '0; wdata[x] = '0; end
    force_k = 0; rand_mode = 1'b0; hold_req = 1'b0; stray_now = 1'b0;
    #2;
    do_reset();

    // Contention from reset: alternating writes starting with m0.
    req = 2'b11; wr = 2'b11; hold_req = 1'b1;
    for (int i = 0; i < 20 && glog.size() < 4; i++) step();
    hold_req = 1'b0; req = '0;
    repeat (3) step();
    check("t4_count", 32'(glog.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < glog.size(); i++) check("t4_order", 32'(glog[i]), 32'(i % 2));

    // Lone m0 write.
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = AW'(3); wdata[0] = 8'hA5;
    run_until("t2", 0, 5);
    check("t2_wren", 32'(bus.WrEN), 32'd1);
    check("t2_rden", 32'(bus.RdEN), 32'd0);
    check("t2_addr", 32'(bus.Reg_File_Adress), 32'd3);
    check("t2_data", 32'(bus.WrData), 32'hA5);
    repeat (2) step();

    // m1 read with a one-cycle Reg File.
    mem[5] = 8'h3C; force_k = 1;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = AW'(5);
    run_until("t3_rden", 4, 5);
    repeat (2) step();
    check("t3_rvalid", 32'(bus.m1_rvalid), 32'd1);
    check("t3_rdata",  32'(bus.m1_rdata),  32'h3C);
    check("t3_rerr",   32'(bus.m1_rerr),   32'd0);
    check("t3_m0",     32'(bus.m0_rvalid), 32'd0);
    repeat (2) step();

    // m0 read that never returns; m1 waits behind it.
    force_k = -1;
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = AW'(9);
    run_until("t5_rden", 4, 5);
    new_op(1, 1'b1);
    for (int i = 1; i <= TO; i++) begin
      step();
      check("t5_rvalid", 32'(bus.m0_rvalid), 32'(i == TO));
    end
    check("t5_rerr",  32'(bus.m0_rerr),  32'd1);
    check("t5_rdata", 32'(bus.m0_rdata), 32'd0);
    check("t5_busy",  32'(bus.arb_busy), 32'd0);
    run_until("t5_m1gnt", 1, 3);
    repeat (2) step();

    // Stray Rd_valid while idle.
    stray_now = 1'b1;
    step(); step();
    check("t6_m0", 32'(bus.m0_rvalid), 32'd0);
    check("t6_m1", 32'(bus.m1_rvalid), 32'd0);

    // Reset while a read is outstanding.
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = AW'(2);
    run_until("t1_rden", 4, 5);
    do_reset();
    repeat (6) step();
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = AW'(1); wdata[0] = 8'h5A;
    run_until("t1_gnt", 0, 5);
    repeat (2) step();

    // Randomized traffic with random Reg File latencies.
    force_k = 0; rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0; req = '0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
